// File: rtl/cdc_bus_arbiter_pkg.sv
// Shared types and helpers for the round-robin bundled-data crossing arbiter.
package cdc_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_ERR      = 2'd3
  } arb_state_e;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_AW      = 4;
  localparam int DEF_DW      = 8;
  localparam int DEF_SETTLE  = 2;
  localparam int DEF_TIMEOUT = 255;

  // Minimum width able to count 0..value-1; never below one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cdc_bus_arbiter_if.sv
// Requester/crossing bundle for cdc_bus_arbiter; slave modport is the arbiter view.
interface cdc_bus_arbiter_if
  import cdc_bus_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) ();

  localparam int IW = clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic [AW-1:0]       bus_addr;
  logic [DW-1:0]       bus_data;
  logic                bus_req_tgl;
  logic                bus_ack_tgl;
  logic                busy;
  logic [IW-1:0]       grant_id;
  logic                err;

  modport master (
    output req_valid, req_addr, req_data, bus_ack_tgl,
    input  req_ready, bus_addr, bus_data, bus_req_tgl, busy, grant_id, err
  );

  modport slave (
    input  req_valid, req_addr, req_data, bus_ack_tgl,
    output req_ready, bus_addr, bus_data, bus_req_tgl, busy, grant_id, err
  );

endinterface

// File: rtl/cdc_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid strictly after ptr, wrapping to index 0.
module rr_arbiter
  import cdc_bus_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = clog2(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // Two passes: indices above the pointer first, then the wrapped lower half.
  always_comb begin
    grant = {N_REQ{1'b0}};
    idx   = {IW{1'b0}};
    any   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && valid[i] && (IW'(i) > ptr)) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end else begin
        any = any;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && valid[i] && (IW'(i) <= ptr)) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/cdc_bus_arbiter.sv
// Round-robin sequencer sharing one addr/data + request-toggle crossing among N_REQ requesters.
// Optional ack timeout with sticky err and ERR lock-up when CDC_ARB_TIMEOUT_EN is defined.
module cdc_bus_arbiter
  import cdc_bus_arbiter_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk_in,
  input  logic              rst,
  cdc_bus_arbiter_if.slave  bus
);

  localparam int IW = clog2(N_REQ);
  localparam int SW = clog2(SETTLE + 1);

  arb_state_e       state_r;
  logic [IW-1:0]    ptr_r;
  logic [SW-1:0]    settle_cnt_r;
  logic             tgl_r;
  logic [AW-1:0]    addr_r;
  logic [DW-1:0]    data_r;
  logic [IW-1:0]    grant_id_r;
  logic [N_REQ-1:0] grant_s;
  logic [IW-1:0]    win_idx_s;
  logic             win_any_s;

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt_r;
  logic          err_r;
  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .valid (bus.req_valid),
    .ptr   (ptr_r),
    .grant (grant_s),
    .idx   (win_idx_s),
    .any   (win_any_s)
  );

  // Accept is only offered from IDLE, which keeps ready one-hot and one pulse per transfer.
  assign bus.req_ready   = (state_r == ST_IDLE) ? grant_s : {N_REQ{1'b0}};
  assign bus.bus_addr    = addr_r;
  assign bus.bus_data    = data_r;
  assign bus.bus_req_tgl = tgl_r;
  assign bus.grant_id    = grant_id_r;
  assign bus.busy        = (state_r != ST_IDLE);

  // Transfer FSM: latch winner, hold data SETTLE cycles, flip toggle, wait for matching ack.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      ptr_r        <= IW'(N_REQ - 1);
      settle_cnt_r <= {SW{1'b0}};
      tgl_r        <= 1'b0;
      addr_r       <= {AW{1'b0}};
      data_r       <= {DW{1'b0}};
      grant_id_r   <= {IW{1'b0}};
`ifdef CDC_ARB_TIMEOUT_EN
      wait_cnt_r   <= {TW{1'b0}};
      err_r        <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_any_s) begin
            addr_r       <= bus.req_addr[int'(win_idx_s)*AW +: AW];
            data_r       <= bus.req_data[int'(win_idx_s)*DW +: DW];
            grant_id_r   <= win_idx_s;
            ptr_r        <= win_idx_s;
            settle_cnt_r <= {SW{1'b0}};
            state_r      <= ST_SETTLE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_r == SW'(SETTLE - 1)) begin
            tgl_r   <= ~tgl_r;
            state_r <= ST_WAIT_ACK;
`ifdef CDC_ARB_TIMEOUT_EN
            wait_cnt_r <= {TW{1'b0}};
`endif
          end else begin
            settle_cnt_r <= settle_cnt_r + SW'(1);
          end
        end
        ST_WAIT_ACK: begin
          // Compared against the already-flipped toggle, so a match can only land here.
          if (bus.bus_ack_tgl == tgl_r) begin
            state_r <= ST_IDLE;
`ifdef CDC_ARB_TIMEOUT_EN
          end else if (wait_cnt_r == TW'(TIMEOUT - 1)) begin
            state_r <= ST_ERR;
            err_r   <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + TW'(1);
`else
          end else begin
            state_r <= ST_WAIT_ACK;
`endif
          end
        end
`ifdef CDC_ARB_TIMEOUT_EN
        ST_ERR: begin
          state_r <= ST_ERR;
        end
`endif
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_bus_arbiter.sv
// Directed bench for cdc_bus_arbiter (N_REQ=4, AW=4, DW=8, SETTLE=2, TIMEOUT=16).
// Timeout scenario follows CDC_ARB_TIMEOUT_EN when defined.
module tb_cdc_bus_arbiter;
  import cdc_bus_arbiter_pkg::*;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  int   n_vec  = 0;
  int   n_bad  = 0;

  always #5 clk_in = ~clk_in;

  cdc_bus_arbiter_if #(.N_REQ(4), .AW(4), .DW(8)) bif ();

  cdc_bus_arbiter #(
    .N_REQ(4), .AW(4), .DW(8), .SETTLE(2), .TIMEOUT(16)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bif.slave)
  );

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [7:0] d);
    bif.req_addr[i*4 +: 4] = a;
    bif.req_data[i*8 +: 8] = d;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bif.req_valid   = 4'b0000;
    bif.bus_ack_tgl = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Waits for the request flip, returns the ack 3 cycles later, ends in the first IDLE cycle.
  task automatic finish_xfer;
    int w;
    w = 0;
    while (bif.bus_req_tgl === bif.bus_ack_tgl && w < 20) begin
      tick;
      w++;
    end
    n_vec++;
    if (w >= 20) begin n_bad++; $display("FAIL xfer_flip: toggle never flipped within %0d cycles, required flip", w); end
    repeat (3) tick;
    bif.bus_ack_tgl = bif.bus_req_tgl;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    n_vec++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", bif.busy); end
    n_vec++; if (bif.bus_req_tgl !== 1'b0) begin n_bad++; $display("FAIL rst_tgl: got %b expected 0", bif.bus_req_tgl); end
    n_vec++; if (bif.bus_addr !== 4'h0) begin n_bad++; $display("FAIL rst_addr: got %h expected 0", bif.bus_addr); end
    n_vec++; if (bif.bus_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h expected 00", bif.bus_data); end
    n_vec++; if (bif.req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready: got %b expected 0000", bif.req_ready); end
    n_vec++; if (bif.grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_grant: got %0d expected 0", bif.grant_id); end
    n_vec++; if (bif.err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b expected 0", bif.err); end
  endtask

  task automatic test_single;
    set_req(1, 4'h3, 8'hA5);
    bif.req_valid = 4'b0010;
    #1;
    n_vec++; if (bif.req_ready !== 4'b0010) begin n_bad++; $display("FAIL single_ready: got %b expected 0010", bif.req_ready); end
    tick;
    bif.req_valid = 4'b0000;
    #1;
    n_vec++; if (bif.bus_addr !== 4'h3) begin n_bad++; $display("FAIL single_addr: got %h expected 3", bif.bus_addr); end
    n_vec++; if (bif.bus_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h expected a5", bif.bus_data); end
    n_vec++; if (bif.grant_id !== 2'd1) begin n_bad++; $display("FAIL single_grant: got %0d expected 1", bif.grant_id); end
    n_vec++; if (bif.req_ready !== 4'b0000) begin n_bad++; $display("FAIL single_ready_off: got %b expected 0000", bif.req_ready); end
    n_vec++; if (bif.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b expected 1", bif.busy); end
    tick;
    n_vec++; if (bif.bus_req_tgl !== 1'b0) begin n_bad++; $display("FAIL single_tgl_hold: got %b expected 0", bif.bus_req_tgl); end
    tick;
    n_vec++; if (bif.bus_req_tgl !== 1'b1) begin n_bad++; $display("FAIL single_tgl_flip: got %b expected 1", bif.bus_req_tgl); end
    repeat (3) tick;
    bif.bus_ack_tgl = 1'b1;
    #1;
    n_vec++; if (bif.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_ack: got %b expected 1", bif.busy); end
    tick;
    n_vec++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL single_done: got %b expected 0", bif.busy); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy;
    logic [1:0] exp_id;
    do_reset;
    for (int i = 0; i < 4; i++) set_req(i, 4'(i + 4), 8'(8'h10 + i));
    bif.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_id  = 2'(k % 4);
      exp_rdy = 4'b0001 << exp_id;
      n_vec++; if (bif.req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, bif.req_ready, exp_rdy); end
      tick;
      n_vec++; if (bif.grant_id !== exp_id) begin n_bad++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", k, bif.grant_id, exp_id); end
      n_vec++; if (bif.bus_addr !== 4'(exp_id + 4)) begin n_bad++; $display("FAIL rr_addr[%0d]: got %h expected %h", k, bif.bus_addr, exp_id + 4); end
      n_vec++; if (bif.bus_data !== 8'(8'h10 + exp_id)) begin n_bad++; $display("FAIL rr_data[%0d]: got %h expected %h", k, bif.bus_data, 8'h10 + exp_id); end
      finish_xfer;
    end
    bif.req_valid = 4'b0000;
  endtask

  task automatic test_contention;
    do_reset;
    set_req(0, 4'h1, 8'h11);
    set_req(2, 4'h9, 8'h99);
    bif.req_valid = 4'b0001;
    #1;
    n_vec++; if (bif.req_ready !== 4'b0001) begin n_bad++; $display("FAIL cont_first: got %b expected 0001", bif.req_ready); end
    tick;
    bif.req_valid = 4'b0100;
    #1;
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (bif.req_ready !== 4'b0000) begin n_bad++; $display("FAIL cont_hold[%0d]: got %b expected 0000", c, bif.req_ready); end
      tick;
    end
    n_vec++; if (bif.req_ready !== 4'b0000) begin n_bad++; $display("FAIL cont_hold_ack: got %b expected 0000", bif.req_ready); end
    bif.bus_ack_tgl = bif.bus_req_tgl;
    tick;
    n_vec++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL cont_idle: got %b expected 0", bif.busy); end
    n_vec++; if (bif.req_ready !== 4'b0100) begin n_bad++; $display("FAIL cont_ready2: got %b expected 0100", bif.req_ready); end
    tick;
    bif.req_valid = 4'b0000;
    n_vec++; if (bif.grant_id !== 2'd2) begin n_bad++; $display("FAIL cont_grant: got %0d expected 2", bif.grant_id); end
    n_vec++; if (bif.bus_addr !== 4'h9) begin n_bad++; $display("FAIL cont_addr: got %h expected 9", bif.bus_addr); end
    finish_xfer;
  endtask

  task automatic test_reset_mid;
    set_req(0, 4'h5, 8'h3C);
    set_req(3, 4'h7, 8'h77);
    bif.req_valid = 4'b0001;
    tick;
    bif.req_valid = 4'b0000;
    tick;
    tick;
    n_vec++; if (bif.bus_req_tgl === bif.bus_ack_tgl) begin n_bad++; $display("FAIL mid_wait: toggle %b equals ack, required mismatch", bif.bus_req_tgl); end
    rst = 1'b1;
    bif.bus_ack_tgl = 1'b0;
    tick;
    rst = 1'b0;
    n_vec++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b expected 0", bif.busy); end
    n_vec++; if (bif.bus_req_tgl !== 1'b0) begin n_bad++; $display("FAIL mid_tgl: got %b expected 0", bif.bus_req_tgl); end
    n_vec++; if (bif.bus_addr !== 4'h0) begin n_bad++; $display("FAIL mid_addr: got %h expected 0", bif.bus_addr); end
    n_vec++; if (bif.bus_data !== 8'h00) begin n_bad++; $display("FAIL mid_data: got %h expected 00", bif.bus_data); end
    n_vec++; if (bif.req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_ready: got %b expected 0000", bif.req_ready); end
    bif.req_valid = 4'b1001;
    #1;
    n_vec++; if (bif.req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first: got %b expected 0001", bif.req_ready); end
    tick;
    bif.req_valid = 4'b1000;
    n_vec++; if (bif.bus_addr !== 4'h5) begin n_bad++; $display("FAIL mid_addr0: got %h expected 5", bif.bus_addr); end
    finish_xfer;
    n_vec++; if (bif.req_ready !== 4'b1000) begin n_bad++; $display("FAIL mid_second: got %b expected 1000", bif.req_ready); end
    tick;
    bif.req_valid = 4'b0000;
    n_vec++; if (bif.grant_id !== 2'd3) begin n_bad++; $display("FAIL mid_grant3: got %0d expected 3", bif.grant_id); end
    n_vec++; if (bif.bus_data !== 8'h77) begin n_bad++; $display("FAIL mid_data3: got %h expected 77", bif.bus_data); end
    finish_xfer;
  endtask

  task automatic test_spurious;
    logic t0;
    int   bad;
    t0 = bif.bus_req_tgl;
    bif.bus_ack_tgl = ~bif.bus_ack_tgl;
    tick;
    tick;
    n_vec++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL spur_busy: got %b expected 0", bif.busy); end
    n_vec++; if (bif.bus_req_tgl !== t0) begin n_bad++; $display("FAIL spur_tgl: got %b expected %b", bif.bus_req_tgl, t0); end
    n_vec++; if (bif.req_ready !== 4'b0000) begin n_bad++; $display("FAIL spur_ready: got %b expected 0000", bif.req_ready); end
    bif.bus_ack_tgl = ~bif.bus_ack_tgl;
    tick;
    set_req(1, 4'hC, 8'h5A);
    bif.req_valid = 4'b0010;
    #1;
    n_vec++; if (bif.req_ready !== 4'b0010) begin n_bad++; $display("FAIL spur_accept: got %b expected 0010", bif.req_ready); end
    tick;
    bif.req_valid = 4'b0000;
    tick;
    tick;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (bif.busy !== 1'b1) bad++;
      tick;
    end
    n_vec++; if (bad != 0) begin n_bad++; $display("FAIL spur_wait: %0d idle cycles before ack, required 0", bad); end
    bif.bus_ack_tgl = bif.bus_req_tgl;
    tick;
    n_vec++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL spur_done: got %b expected 0", bif.busy); end
  endtask

  task automatic test_timeout;
    int bad;
    set_req(2, 4'hE, 8'h42);
    bif.req_valid = 4'b0100;
    tick;
    bif.req_valid = 4'b0000;
    tick;
    tick;
    bad = 0;
`ifdef CDC_ARB_TIMEOUT_EN
    for (int c = 1; c <= 16; c++) begin
      if (bif.err !== 1'b0 || bif.busy !== 1'b1) bad++;
      tick;
    end
    n_vec++; if (bad != 0) begin n_bad++; $display("FAIL to_early: %0d bad cycles during wait, required 0", bad); end
    n_vec++; if (bif.err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b expected 1", bif.err); end
    bif.req_valid = 4'b1111;
    repeat (5) tick;
    n_vec++; if (bif.req_ready !== 4'b0000) begin n_bad++; $display("FAIL to_ready: got %b expected 0000", bif.req_ready); end
    n_vec++; if (bif.busy !== 1'b1) begin n_bad++; $display("FAIL to_busy: got %b expected 1", bif.busy); end
    n_vec++; if (bif.bus_addr !== 4'hE) begin n_bad++; $display("FAIL to_frozen: got %h expected e", bif.bus_addr); end
`else
    for (int c = 0; c < 1000; c++) begin
      if (bif.err !== 1'b0 || bif.busy !== 1'b1) bad++;
      tick;
    end
    n_vec++; if (bad != 0) begin n_bad++; $display("FAIL to_wait_forever: %0d bad cycles, required 0", bad); end
`endif
    do_reset;
    n_vec++; if (bif.err !== 1'b0 || bif.busy !== 1'b0) begin n_bad++; $display("FAIL to_reset: err %b busy %b expected 0 0", bif.err, bif.busy); end
  endtask

  initial begin
    bif.req_valid   = 4'b0000;
    bif.req_addr    = 16'h0000;
    bif.req_data    = 32'h0000_0000;
    bif.bus_ack_tgl = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_contention;
    test_reset_mid;
    test_spurious;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
